// File: rtl/usbdev_pkg.sv
// Shared widths, endpoint config record and fetch FSM states for the USB device IN data supply.
package usbdev_pkg;

  localparam int unsigned NumInEps         = 12;
  localparam int unsigned NumBuffers       = 32;
  localparam int unsigned MaxInPktSizeByte = 64;

  localparam int unsigned BufW  = $clog2(NumBuffers);
  localparam int unsigned PktW  = $clog2(MaxInPktSizeByte);
  localparam int unsigned WordW = PktW - 2;
  localparam int unsigned SizeW = PktW + 1;
  localparam int unsigned AddrW = BufW + WordW;

  typedef logic [BufW-1:0]  buf_id_t;
  typedef logic [SizeW-1:0] pkt_size_t;
  typedef logic [WordW-1:0] word_idx_t;

  typedef struct packed {
    buf_id_t   buf_id;
    pkt_size_t size;
    logic      rdy;
  } in_ep_cfg_t;

  typedef enum logic [1:0] {
    FetchIdle = 2'd0,
    FetchReq  = 2'd1,
    FetchWait = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/usbdev_in_ep_cfg.sv
// Per-endpoint IN packet config (buffer, size, ready) with software write and retire priority.
module usbdev_in_ep_cfg
  import usbdev_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_link_reset,
  input  logic                i_cfg_we,
  input  logic [3:0]          i_cfg_ep,
  input  logic [BufW-1:0]     i_cfg_buf,
  input  logic [SizeW-1:0]    i_cfg_size,
  input  logic                i_cfg_rdy,
  input  logic                i_retire,
  input  logic [3:0]          i_retire_ep,
  input  logic [3:0]          i_rd_ep,
  output logic [BufW-1:0]     o_rd_buf,
  output logic [SizeW-1:0]    o_rd_size,
  output logic [NumInEps-1:0] o_rdy
);

  in_ep_cfg_t r_cfg [NumInEps];

  // Later assignments win: retire < software write < link reset for the ready bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInEps; i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumInEps; i++) begin
        if (i_retire && (i_retire_ep == 4'(i))) begin
          r_cfg[i].rdy <= 1'b0;
        end
        if (i_cfg_we && (i_cfg_ep == 4'(i))) begin
          r_cfg[i].buf_id <= i_cfg_buf;
          r_cfg[i].size   <= i_cfg_size;
          r_cfg[i].rdy    <= i_cfg_rdy;
        end
        if (i_link_reset) begin
          r_cfg[i].rdy <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_rd_buf  = '0;
    o_rd_size = '0;
    o_rdy     = '0;
    for (int i = 0; i < NumInEps; i++) begin
      o_rdy[i] = r_cfg[i].rdy;
      if (i_rd_ep == 4'(i)) begin
        o_rd_buf  = r_cfg[i].buf_id;
        o_rd_size = r_cfg[i].size;
      end
    end
  end

endmodule

// File: rtl/usbdev_in_ep_supply.sv
// IN endpoint data supply: per-transaction snapshot, word fetch from packet SRAM, byte mux, sent flags.
// Build option USBDEV_IN_SENT_STICKY_EN makes in_sent_o sticky until cleared via in_sent_clr_i.
//
// state     | meaning
// FetchIdle | no SRAM access outstanding
// FetchReq  | mem_req_o high for one cycle with mem_addr_o
// FetchWait | mem_rdata_i valid, captured into the word register
module usbdev_in_ep_supply
  import usbdev_pkg::*;
(
  input  logic                clk_48mhz_i,
  input  logic                rst_ni,
  input  logic                link_reset_i,
  input  logic                cfg_we_i,
  input  logic [3:0]          cfg_ep_i,
  input  logic [BufW-1:0]     cfg_buf_i,
  input  logic [PktW:0]       cfg_size_i,
  input  logic                cfg_rdy_i,
  input  logic                in_xact_starting_i,
  input  logic [3:0]          in_xact_start_ep_i,
  input  logic [3:0]          in_ep_current_i,
  input  logic                in_ep_newpkt_i,
  input  logic [PktW-1:0]     in_ep_get_addr_i,
  input  logic                in_ep_data_get_i,
  input  logic                in_ep_xact_end_i,
  input  logic                in_ep_rollback_i,
  output logic [NumInEps-1:0] in_ep_has_data_o,
  output logic [7:0]          in_ep_data_o,
  output logic [NumInEps-1:0] in_ep_data_done_o,
  output logic                mem_req_o,
  output logic [AddrW-1:0]    mem_addr_o,
  input  logic [31:0]         mem_rdata_i,
  output logic [NumInEps-1:0] in_sent_o,
  input  logic [NumInEps-1:0] in_sent_clr_i
);

  buf_id_t      w_start_buf;
  pkt_size_t    w_start_size;
  buf_id_t      r_cur_buf;
  pkt_size_t    r_cur_size;
  logic         r_wrap;
  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [AddrW-1:0] r_mem_addr;
  logic [AddrW-1:0] w_addr_next;
  logic         w_word_load;
  logic [31:0]  r_word;
  logic         w_retire;
  buf_id_t      w_fetch_buf;
  pkt_size_t    w_get_zx;
  logic         w_get_at_zero;
  logic         w_get_fetch;
  logic         w_done_any;
  logic [NumInEps-1:0] w_sent_set;
  logic [NumInEps-1:0] r_sent;

  // A rollback alongside xact_end keeps the packet ready.
  assign w_retire = in_ep_xact_end_i & ~in_ep_rollback_i;

  usbdev_in_ep_cfg u_cfg (
    .clk_i        (clk_48mhz_i),
    .rst_ni       (rst_ni),
    .i_link_reset (link_reset_i),
    .i_cfg_we     (cfg_we_i),
    .i_cfg_ep     (cfg_ep_i),
    .i_cfg_buf    (cfg_buf_i),
    .i_cfg_size   (cfg_size_i),
    .i_cfg_rdy    (cfg_rdy_i),
    .i_retire     (w_retire),
    .i_retire_ep  (in_ep_current_i),
    .i_rd_ep      (in_xact_start_ep_i),
    .o_rd_buf     (w_start_buf),
    .o_rd_size    (w_start_size),
    .o_rdy        (in_ep_has_data_o)
  );

  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      r_cur_buf  <= '0;
      r_cur_size <= '0;
    end else if (in_xact_starting_i) begin
      r_cur_buf  <= w_start_buf;
      r_cur_size <= w_start_size;
    end
  end

  assign w_fetch_buf   = in_xact_starting_i ? w_start_buf : r_cur_buf;
  assign w_get_zx      = {1'b0, in_ep_get_addr_i};
  assign w_get_at_zero = in_ep_get_addr_i == '0;

  // A consumed byte landing on offset 0 means the offset wrapped past a full-size packet.
  assign w_get_fetch = (in_ep_get_addr_i[1:0] == 2'b00) && !w_get_at_zero &&
                       (w_get_zx < r_cur_size);

  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      r_wrap <= 1'b0;
    end else if (in_xact_starting_i || in_ep_newpkt_i) begin
      r_wrap <= 1'b0;
    end else if (in_ep_data_get_i && w_get_at_zero) begin
      r_wrap <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_mem_addr;
    w_word_load  = 1'b0;
    case (r_state)
      FetchReq:  w_state_next = FetchWait;
      FetchWait: begin
        w_state_next = FetchIdle;
        w_word_load  = 1'b1;
      end
      default:   w_state_next = FetchIdle;
    endcase
    if (in_ep_newpkt_i) begin
      w_state_next = FetchReq;
      w_addr_next  = {w_fetch_buf, word_idx_t'(0)};
    end else if (in_ep_data_get_i && w_get_fetch) begin
      w_state_next = FetchReq;
      w_addr_next  = {r_cur_buf, in_ep_get_addr_i[PktW-1:2]};
    end
    if (link_reset_i) begin
      w_state_next = FetchIdle;
      w_word_load  = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      r_state    <= FetchIdle;
      r_mem_addr <= '0;
      r_word     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mem_addr <= w_addr_next;
      if (w_word_load) begin
        r_word <= mem_rdata_i;
      end
    end
  end

  assign mem_req_o    = (r_state == FetchReq) && !link_reset_i;
  assign mem_addr_o   = r_mem_addr;
  assign in_ep_data_o = word_byte(r_word, in_ep_get_addr_i[1:0]);

  assign w_done_any = (w_get_zx >= r_cur_size) || r_wrap ||
                      (in_ep_data_get_i && w_get_at_zero);

  always_comb begin
    in_ep_data_done_o = '0;
    w_sent_set        = '0;
    for (int i = 0; i < NumInEps; i++) begin
      if (in_ep_current_i == 4'(i)) begin
        in_ep_data_done_o[i] = w_done_any;
        w_sent_set[i]        = w_retire;
      end
    end
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      r_sent <= '0;
    end else begin
`ifdef USBDEV_IN_SENT_STICKY_EN
      r_sent <= (r_sent & ~in_sent_clr_i) | w_sent_set;
`else
      r_sent <= w_sent_set;
`endif
    end
  end

`ifndef USBDEV_IN_SENT_STICKY_EN
  logic w_unused_sent_clr;
  assign w_unused_sent_clr = ^in_sent_clr_i;
`endif

  assign in_sent_o = r_sent;

endmodule

// File: tb/tb_usbdev_in_ep_supply.sv
// Self-checking bench for usbdev_in_ep_supply: SRAM model with expected-address scoreboard plus vector table.
module tb_usbdev_in_ep_supply;
  import usbdev_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_ni = 1'b0, link_reset_i = 1'b0, cfg_we_i = 1'b0, cfg_rdy_i = 1'b0;
  logic [3:0]  cfg_ep_i = '0, in_xact_start_ep_i = '0, in_ep_current_i = '0;
  logic [4:0]  cfg_buf_i = '0;
  logic [6:0]  cfg_size_i = '0;
  logic        in_xact_starting_i = 1'b0, in_ep_newpkt_i = 1'b0, in_ep_data_get_i = 1'b0;
  logic [5:0]  in_ep_get_addr_i = '0;
  logic        in_ep_xact_end_i = 1'b0, in_ep_rollback_i = 1'b0;
  logic [11:0] in_ep_has_data_o, in_ep_data_done_o, in_sent_o;
  logic [11:0] in_sent_clr_i = '0;
  logic [7:0]  in_ep_data_o;
  logic        mem_req_o;
  logic [8:0]  mem_addr_o;
  logic [31:0] mem_rdata_i = 32'hBAD0BAD0;

  usbdev_in_ep_supply dut (
    .clk_48mhz_i(clk), .rst_ni(rst_ni), .link_reset_i(link_reset_i),
    .cfg_we_i(cfg_we_i), .cfg_ep_i(cfg_ep_i), .cfg_buf_i(cfg_buf_i), .cfg_size_i(cfg_size_i),
    .cfg_rdy_i(cfg_rdy_i), .in_xact_starting_i(in_xact_starting_i),
    .in_xact_start_ep_i(in_xact_start_ep_i), .in_ep_current_i(in_ep_current_i),
    .in_ep_newpkt_i(in_ep_newpkt_i), .in_ep_get_addr_i(in_ep_get_addr_i),
    .in_ep_data_get_i(in_ep_data_get_i), .in_ep_xact_end_i(in_ep_xact_end_i),
    .in_ep_rollback_i(in_ep_rollback_i), .in_ep_has_data_o(in_ep_has_data_o),
    .in_ep_data_o(in_ep_data_o), .in_ep_data_done_o(in_ep_data_done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .in_sent_o(in_sent_o), .in_sent_clr_i(in_sent_clr_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_fetch  = 0;
  logic [8:0] exp_addr_q[$];
  logic [8:0] exp_addr;
  logic       req_seen = 1'b0;
  logic [8:0] req_addr = '0;

  function automatic logic [7:0] exp_byte(input int b, input int k);
    return 8'((k + 1) * 17 + (b - 5) * 3);
  endfunction

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    int b;
    int w;
    b = int'(a[8:4]);
    w = int'(a[3:0]);
    return {exp_byte(b, 4*w+3), exp_byte(b, 4*w+2), exp_byte(b, 4*w+1), exp_byte(b, 4*w)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM request monitor: every request must match the next expected address.
  always @(negedge clk) begin
    req_seen = mem_req_o;
    req_addr = mem_addr_o;
    if (mem_req_o === 1'b1) begin
      n_fetch++;
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_errors++;
        $display("FAIL mem_req_unexpected: got addr 0x%0h, expected no request", mem_addr_o);
      end else begin
        exp_addr = exp_addr_q.pop_front();
        if (mem_addr_o !== exp_addr) begin
          n_errors++;
          $display("FAIL mem_addr: got 0x%0h, expected 0x%0h", mem_addr_o, exp_addr);
        end
      end
    end
  end

  // Read data is valid exactly one cycle after the request cycle, garbage otherwise.
  always @(posedge clk) begin
    #1;
    mem_rdata_i = req_seen ? mem_word(req_addr) : 32'hBAD0BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ep, input int bufid, input int size, input logic rdy);
    cfg_we_i = 1'b1; cfg_ep_i = 4'(ep); cfg_buf_i = 5'(bufid); cfg_size_i = 7'(size);
    cfg_rdy_i = rdy;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic start_pkt(input int ep, input int bufid, input logic [11:0] exp_done);
    in_xact_starting_i = 1'b1; in_xact_start_ep_i = 4'(ep);
    tick();
    in_xact_starting_i = 1'b0;
    in_ep_current_i = 4'(ep); in_ep_newpkt_i = 1'b1; in_ep_get_addr_i = '0;
    exp_addr_q.push_back({5'(bufid), 4'd0});
    tick();
    in_ep_newpkt_i = 1'b0;
    check("req_after_newpkt", 32'(mem_req_o), 32'd1);
    check("done_first_cycle", 32'(in_ep_data_done_o), 32'(exp_done));
    tick();
    tick();
  endtask

  task automatic get_step(input logic [5:0] addr, input int size, input int bufid);
    logic fetch;
    in_ep_get_addr_i = addr; in_ep_data_get_i = 1'b1;
    fetch = (addr[1:0] == 2'b00) && (addr != 6'd0) && (int'(addr) < size);
    if (fetch) exp_addr_q.push_back({5'(bufid), addr[5:2]});
    tick();
    in_ep_data_get_i = 1'b0;
    if (fetch) begin
      tick();
      tick();
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [7:0]  dat;
    logic        chk_dat;
    logic [11:0] done;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{6'd1, 8'h22, 1'b1, 12'h000};
    vecs[1] = '{6'd2, 8'h33, 1'b1, 12'h000};
    vecs[2] = '{6'd3, 8'h44, 1'b1, 12'h000};
    vecs[3] = '{6'd4, 8'h55, 1'b1, 12'h000};
    vecs[4] = '{6'd5, 8'h66, 1'b1, 12'h000};
    vecs[5] = '{6'd6, 8'h77, 1'b1, 12'h000};
    vecs[6] = '{6'd7, 8'h88, 1'b1, 12'h000};
    vecs[7] = '{6'd8, 8'h00, 1'b0, 12'h004};

    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("rst_has_data", 32'(in_ep_has_data_o), 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_sent", 32'(in_sent_o), 32'h0);
    check("rst_done", 32'(in_ep_data_done_o), 32'h001);
    check("rst_data", 32'(in_ep_data_o), 32'h0);

    cfg_write(2, 5, 8, 1'b1);
    check("cfg_has_data", 32'(in_ep_has_data_o), 32'h004);

    start_pkt(2, 5, 12'h000);
    check("byte_off0", 32'(in_ep_data_o), 32'h11);
    for (int i = 0; i < 8; i++) begin
      get_step(vecs[i].addr, 8, 5);
      if (vecs[i].chk_dat) check("vec_byte", 32'(in_ep_data_o), 32'(vecs[i].dat));
      check("vec_done", 32'(in_ep_data_done_o), 32'(vecs[i].done));
    end

    in_ep_rollback_i = 1'b1;
    tick();
    in_ep_rollback_i = 1'b0;
    check("rollback_has_data", 32'(in_ep_has_data_o), 32'h004);
    check("rollback_sent", 32'(in_sent_o), 32'h0);

    in_ep_xact_end_i = 1'b1;
    tick();
    in_ep_xact_end_i = 1'b0;
    check("end_has_data", 32'(in_ep_has_data_o), 32'h0);
    check("end_sent", 32'(in_sent_o), 32'h004);
    tick();
`ifdef USBDEV_IN_SENT_STICKY_EN
    check("sticky_hold", 32'(in_sent_o), 32'h004);
    in_sent_clr_i = 12'h004;
    tick();
    in_sent_clr_i = '0;
    check("sticky_clr", 32'(in_sent_o), 32'h0);
`else
    check("sent_pulse_end", 32'(in_sent_o), 32'h0);
`endif

    cfg_write(12, 3, 4, 1'b1);
    cfg_write(15, 3, 4, 1'b1);
    check("bad_ep_ignored", 32'(in_ep_has_data_o), 32'h0);

    cfg_write(2, 5, 8, 1'b1);
    cfg_we_i = 1'b1; cfg_ep_i = 4'd2; cfg_buf_i = 5'd5; cfg_size_i = 7'd8; cfg_rdy_i = 1'b1;
    in_ep_xact_end_i = 1'b1;
`ifdef USBDEV_IN_SENT_STICKY_EN
    in_sent_clr_i = 12'h004;
`endif
    tick();
    cfg_we_i = 1'b0; in_ep_xact_end_i = 1'b0; in_sent_clr_i = '0;
    check("cfg_wins_rdy", 32'(in_ep_has_data_o), 32'h004);
    check("cfg_wins_sent", 32'(in_sent_o), 32'h004);
    tick();
`ifdef USBDEV_IN_SENT_STICKY_EN
    check("sticky_set_wins", 32'(in_sent_o), 32'h004);
    in_sent_clr_i = 12'h004;
    tick();
    in_sent_clr_i = '0;
`endif
    check("sent_cleared", 32'(in_sent_o), 32'h0);

    start_pkt(2, 5, 12'h000);
    cfg_write(2, 7, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      get_step(6'(k), 8, 5);
      check("snapshot_done", 32'(in_ep_data_done_o), 32'h0);
    end
    check("snapshot_byte4", 32'(in_ep_data_o), 32'h55);

    cfg_write(3, 9, 0, 1'b1);
    start_pkt(3, 9, 12'h008);

    cfg_write(1, 31, 64, 1'b1);
    base = n_fetch;
    start_pkt(1, 31, 12'h000);
    for (int k = 1; k <= 64; k++) begin
      get_step(6'(k % 64), 64, 31);
      if (k < 64) check("full_byte", 32'(in_ep_data_o), 32'(exp_byte(31, k)));
      check("full_done", 32'(in_ep_data_done_o), (k == 64) ? 32'h002 : 32'h0);
    end
    check("full_fetch_count", 32'(n_fetch - base), 32'd16);

    cfg_write(4, 6, 8, 1'b1);
    check("pre_link_reset_rdy", 32'(in_ep_has_data_o), 32'h01E);
    in_xact_starting_i = 1'b1; in_xact_start_ep_i = 4'd4;
    tick();
    in_xact_starting_i = 1'b0;
    in_ep_current_i = 4'd4; in_ep_newpkt_i = 1'b1; in_ep_get_addr_i = '0;
    tick();
    in_ep_newpkt_i = 1'b0;
    link_reset_i = 1'b1;
    #1;
    check("link_reset_no_req", 32'(mem_req_o), 32'h0);
    tick();
    link_reset_i = 1'b0;
    check("link_reset_rdy", 32'(in_ep_has_data_o), 32'h0);
    tick();
    tick();
    check("link_reset_discard", 32'(in_ep_data_o), 32'(exp_byte(31, 60)));

    tick();
    check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
